// File: rtl/ret_stack_if.sv
// Command/status bundle for the return-address stack.
// The bus itself is a plain inout port on ret_stack so its tristate stays outside the interface.
//   push/pop/inc/es : commands from the sequencer (master -> slave)
//   top/count       : current top entry and number of valid entries
//   full/empty      : occupancy flags
//   ovf/unf         : sticky overflow / underflow flags
interface ret_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             inc;
  logic             es;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, inc, es,
    input  top, count, full, empty, ovf, unf
  );

  modport slave (
    input  push, pop, inc, es,
    output top, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/ret_stack.sv
// Parametrised return-address stack for nested JMS/return sequences.
// Entries live in a circular buffer: entry i (0 = oldest) sits at (base + i) mod DEPTH,
// so the overwrite-oldest policy only has to advance the base pointer.
//   clk  : system clock
//   clr  : synchronous active-high reset (storage itself is not cleared)
//   bus  : shared bus, sampled on push, driven with top on es & ~push
//   rs   : command/status interface (slave side)
module ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter bit          WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  ret_stack_if.slave       rs
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = $clog2(2 * DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    base_q, base_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PW-1:0]    push_idx;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    next_top_idx;

  // Reduce a sum below 2*DEPTH to a buffer index; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_idx(input logic [SW-1:0] s);
    if (s >= SW'(DEPTH)) return PW'(s - SW'(DEPTH));
    else                 return PW'(s);
  endfunction

  // Next-state: command priority is push/pop pair, push, pop, inc.
  always_comb begin
    mem_d   = mem_q;
    base_d  = base_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    push_idx = wrap_idx(SW'(base_q) + SW'(count_q));
    // Adding DEPTH-1 instead of subtracting 1 keeps the sum non-negative.
    top_idx  = wrap_idx(SW'(base_q) + SW'(count_q) + SW'(DEPTH - 1));

    if (rs.push && rs.pop && !empty_q) begin
      mem_d[top_idx] = bus;
    end else if (rs.push) begin
      if (!full_q) begin
        mem_d[push_idx] = bus;
        count_d         = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
        if (WRAP) begin
          // Oldest slot becomes the new top; the next-oldest becomes the base.
          mem_d[base_q] = bus;
          base_d        = wrap_idx(SW'(base_q) + SW'(1));
        end
      end
    end else if (rs.pop) begin
      if (!empty_q) count_d = count_q - CW'(1);
      else          unf_d   = 1'b1;
    end else if (rs.inc) begin
      if (!empty_q) mem_d[top_idx] = mem_q[top_idx] + WIDTH'(1);
      else          unf_d          = 1'b1;
    end

    next_top_idx = wrap_idx(SW'(base_d) + SW'(count_d) + SW'(DEPTH - 1));
    top_d        = (count_d == '0) ? '0 : mem_d[next_top_idx];
    full_d       = (count_d == CW'(DEPTH));
    empty_d      = (count_d == '0);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      base_q  <= '0;
      count_q <= '0;
      top_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      top_q   <= top_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; clr leaves contents alone since count gates visibility.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  // push wins over es so the bus is never driven and sampled together.
  assign bus = (rs.es && !rs.push) ? top_q : {WIDTH{1'bz}};

  assign rs.top   = top_q;
  assign rs.count = count_q;
  assign rs.full  = full_q;
  assign rs.empty = empty_q;
  assign rs.ovf   = ovf_q;
  assign rs.unf   = unf_q;

endmodule
